// File: rtl/cache_mem_arbiter.sv
// Shares one main-memory word port between the I-cache (port 0) and D-cache (port 1).
// A granted line miss runs an optional writeback burst, then a refill burst, then pulses done.
module cache_mem_arbiter #(
  parameter int OFFSET = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  input  logic [31:0]       req_addr0,
  input  logic [31:0]       req_addr1,
  input  logic [1:0]        req_wb,
  input  logic [31:0]       wb_addr0,
  input  logic [31:0]       wb_addr1,
  input  logic [31:0]       wb_data0,
  input  logic [31:0]       wb_data1,
  output logic [1:0]        grant,
  output logic [OFFSET-1:0] word_idx,
  output logic [1:0]        rvalid,
  output logic [31:0]       rdata,
  output logic [1:0]        done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [CNT_W-1:0]  miss_cnt0,
  output logic [CNT_W-1:0]  miss_cnt1
);

  localparam int LW = 30 - OFFSET;
  localparam logic [OFFSET-1:0] LAST_IDX = '1;

  typedef enum logic [2:0] {IDLE, GRANT, WB, RD, DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        grant_q;
  logic              port_q;
  logic              last_q;
  logic              win;
  logic              wb_flag_q;
  logic [LW-1:0]     miss_line_q;
  logic [LW-1:0]     wb_line_q;
  logic [OFFSET-1:0] idx_q;
  logic [OFFSET-1:0] rd_idx_q;
  logic [1:0]        rvalid_q;
  logic [31:0]       rdata_q;
  logic [CNT_W-1:0]  cnt0_q, cnt1_q;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{req_addr0[OFFSET+1:0], req_addr1[OFFSET+1:0],
                              wb_addr0[OFFSET+1:0], wb_addr1[OFFSET+1:0]};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Round-robin pick: a lone requester wins, a tie goes to the port that did not win last.
  always_comb begin
    win = req_valid[1];
    if (req_valid == 2'b11) win = ~last_q;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; bursts advance one word per acknowledged access.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req_valid) state_d = GRANT;
      GRANT:   state_d = wb_flag_q ? WB : RD;
      WB:      if (mem_ack && idx_q == LAST_IDX) state_d = RD;
      RD:      if (mem_ack && idx_q == LAST_IDX) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant, latched line addresses, word counters, refill data and miss counters.
  // idx_q addresses memory; rd_idx_q lags it so word_idx names the word shown with rvalid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_q     <= '0;
      port_q      <= 1'b0;
      last_q      <= 1'b1;
      wb_flag_q   <= 1'b0;
      miss_line_q <= '0;
      wb_line_q   <= '0;
      idx_q       <= '0;
      rd_idx_q    <= '0;
      rvalid_q    <= '0;
      rdata_q     <= '0;
      cnt0_q      <= '0;
      cnt1_q      <= '0;
    end else begin
      rvalid_q <= (state_q == RD && mem_ack) ? grant_q : 2'b00;
      if (state_q == RD && mem_ack) rdata_q <= mem_rdata;
      case (state_q)
        IDLE: begin
          if (|req_valid) begin
            grant_q     <= win ? 2'b10 : 2'b01;
            port_q      <= win;
            last_q      <= win;
            wb_flag_q   <= req_wb[win];
            miss_line_q <= win ? req_addr1[31:OFFSET+2] : req_addr0[31:OFFSET+2];
            wb_line_q   <= win ? wb_addr1[31:OFFSET+2] : wb_addr0[31:OFFSET+2];
          end
        end
        GRANT: begin
          idx_q    <= '0;
          rd_idx_q <= '0;
        end
        WB: begin
          if (mem_ack) idx_q <= idx_q + 1'b1;
        end
        RD: begin
          if (mem_ack) begin
            idx_q    <= idx_q + 1'b1;
            rd_idx_q <= idx_q;
          end
        end
        DONE: begin
          grant_q  <= '0;
          idx_q    <= '0;
          rd_idx_q <= '0;
          if (port_q) cnt1_q <= sat_inc(cnt1_q);
          else        cnt0_q <= sat_inc(cnt0_q);
        end
        default: ;
      endcase
    end
  end

  // Memory-side and cache-side outputs decoded from the current state.
  always_comb begin
    mem_req   = (state_q == WB) || (state_q == RD);
    mem_we    = (state_q == WB);
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == WB) begin
      mem_addr  = {wb_line_q, idx_q, 2'b00};
      mem_wdata = port_q ? wb_data1 : wb_data0;
    end else if (state_q == RD) begin
      mem_addr  = {miss_line_q, idx_q, 2'b00};
    end
    word_idx  = (state_q == RD || state_q == DONE) ? rd_idx_q : idx_q;
    done      = (state_q == DONE) ? grant_q : 2'b00;
  end

  assign grant     = grant_q;
  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;
  assign miss_cnt0 = cnt0_q;
  assign miss_cnt1 = cnt1_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed testbench for cache_mem_arbiter (OFFSET=3, CNT_W=4).
module tb_cache_mem_arbiter;

  localparam logic [31:0] KEY = 32'h5A5A_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [31:0] req_addr0, req_addr1;
  logic [1:0]  req_wb;
  logic [31:0] wb_addr0, wb_addr1;
  logic [31:0] wb_data0, wb_data1;
  logic [1:0]  grant;
  logic [2:0]  word_idx;
  logic [1:0]  rvalid;
  logic [31:0] rdata;
  logic [1:0]  done;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [3:0]  miss_cnt0, miss_cnt1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Cache victim data and memory read data are simple functions of index/address.
  assign wb_data0  = 32'hB0B0_0000 | {29'b0, word_idx};
  assign wb_data1  = 32'hC1C1_0000 | {29'b0, word_idx};
  assign mem_rdata = mem_addr ^ KEY;

  cache_mem_arbiter #(.OFFSET(3), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid),
    .req_addr0(req_addr0), .req_addr1(req_addr1), .req_wb(req_wb),
    .wb_addr0(wb_addr0), .wb_addr1(wb_addr1), .wb_data0(wb_data0), .wb_data1(wb_data1),
    .grant(grant), .word_idx(word_idx), .rvalid(rvalid), .rdata(rdata), .done(done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .miss_cnt0(miss_cnt0), .miss_cnt1(miss_cnt1)
  );

  task automatic pulse_reset();
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; req_valid = 2'b00; req_wb = 2'b00; mem_ack = 1'b0;
    req_addr0 = '0; req_addr1 = '0; wb_addr0 = '0; wb_addr1 = '0;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (grant !== 2'b00 || done !== 2'b00 || rvalid !== 2'b00)
      begin n_fail++; $display("FAIL reset_ctl grant=%b done=%b rvalid=%b want 0", grant, done, rvalid); end
    n_tests++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0)
      begin n_fail++; $display("FAIL reset_mem req=%b we=%b addr=%h wdata=%h want 0", mem_req, mem_we, mem_addr, mem_wdata); end
    n_tests++;
    if (word_idx !== 3'd0 || rdata !== 32'h0 || miss_cnt0 !== 4'd0 || miss_cnt1 !== 4'd0)
      begin n_fail++; $display("FAIL reset_data idx=%0d rdata=%h c0=%0d c1=%0d want 0", word_idx, rdata, miss_cnt0, miss_cnt1); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_port0_clean();
    logic        er;
    logic [31:0] ea;
    logic [1:0]  eg, erv, ed;
    req_addr0 = 32'h0000_1234; req_wb = 2'b00; mem_ack = 1'b1; req_valid = 2'b01;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      er  = (c >= 2 && c <= 9);
      ea  = er ? 32'h1220 + 32'(4 * (c - 2)) : 32'h0;
      eg  = (c >= 1 && c <= 10) ? 2'b01 : 2'b00;
      erv = (c >= 3 && c <= 10) ? 2'b01 : 2'b00;
      ed  = (c == 10) ? 2'b01 : 2'b00;
      n_tests++;
      if (mem_req !== er || mem_addr !== ea || mem_we !== 1'b0)
        begin n_fail++; $display("FAIL p0_mem c=%0d req=%b addr=%h we=%b want req=%b addr=%h we=0", c, mem_req, mem_addr, mem_we, er, ea); end
      n_tests++;
      if (grant !== eg || rvalid !== erv || done !== ed)
        begin n_fail++; $display("FAIL p0_ctl c=%0d grant=%b rvalid=%b done=%b want %b %b %b", c, grant, rvalid, done, eg, erv, ed); end
      if (erv != 2'b00) begin
        n_tests++;
        if (word_idx !== 3'(c - 3) || rdata !== ((32'h1220 + 32'(4 * (c - 3))) ^ KEY))
          begin n_fail++; $display("FAIL p0_data c=%0d idx=%0d rdata=%h want idx=%0d rdata=%h", c, word_idx, rdata, c - 3, (32'h1220 + 32'(4 * (c - 3))) ^ KEY); end
      end
      if (c == 10) req_valid = 2'b00;
    end
    n_tests++;
    if (miss_cnt0 !== 4'd1)
      begin n_fail++; $display("FAIL p0_cnt got %0d want 1", miss_cnt0); end
  endtask

  task automatic test_port1_dirty();
    logic        ewe, er;
    logic [31:0] ea, ew;
    logic [1:0]  eg, erv;
    int          ndone = 0;
    req_addr1 = 32'h0000_4000; wb_addr1 = 32'h0000_8000; req_wb = 2'b10;
    mem_ack = 1'b1; req_valid = 2'b10;
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      ewe = (c >= 2 && c <= 9);
      er  = (c >= 2 && c <= 17);
      ea  = ewe ? 32'h8000 + 32'(4 * (c - 2)) : (er ? 32'h4000 + 32'(4 * (c - 10)) : 32'h0);
      ew  = ewe ? (32'hC1C1_0000 | 32'(c - 2)) : 32'h0;
      eg  = (c >= 1 && c <= 18) ? 2'b10 : 2'b00;
      erv = (c >= 11 && c <= 18) ? 2'b10 : 2'b00;
      n_tests++;
      if (mem_req !== er || mem_we !== ewe || mem_addr !== ea || mem_wdata !== ew)
        begin n_fail++; $display("FAIL p1_mem c=%0d req=%b we=%b addr=%h wdata=%h want %b %b %h %h", c, mem_req, mem_we, mem_addr, mem_wdata, er, ewe, ea, ew); end
      n_tests++;
      if (grant !== eg || rvalid !== erv)
        begin n_fail++; $display("FAIL p1_ctl c=%0d grant=%b rvalid=%b want %b %b", c, grant, rvalid, eg, erv); end
      if (erv != 2'b00) begin
        n_tests++;
        if (word_idx !== 3'(c - 11) || rdata !== ((32'h4000 + 32'(4 * (c - 11))) ^ KEY))
          begin n_fail++; $display("FAIL p1_data c=%0d idx=%0d rdata=%h want idx=%0d", c, word_idx, rdata, c - 11); end
      end
      if (done != 2'b00) begin
        ndone++;
        n_tests++;
        if (done !== 2'b10 || c != 18)
          begin n_fail++; $display("FAIL p1_done c=%0d done=%b want c=18 done=10", c, done); end
        req_valid = 2'b00;
      end
    end
    n_tests++;
    if (ndone != 1 || miss_cnt1 !== 4'd1 || miss_cnt0 !== 4'd1)
      begin n_fail++; $display("FAIL p1_summary ndone=%0d c1=%0d c0=%0d want 1 1 1", ndone, miss_cnt1, miss_cnt0); end
  endtask

  task automatic test_round_robin();
    logic [1:0] order [4];
    logic [1:0] prev_g = 2'b00;
    logic       done_prev = 1'b0;
    int         ngr = 0, overlaps = 0, gap_bad = 0, done_bad = 0;
    req_addr0 = 32'h0000_1000; req_addr1 = 32'h0000_2000; req_wb = 2'b00; mem_ack = 1'b1;
    req_valid = 2'b11;
    pulse_reset();
    for (int c = 1; c <= 44; c++) begin
      @(negedge clk);
      if (grant == 2'b11) overlaps++;
      if (done_prev && grant != 2'b00) gap_bad++;
      if (done != 2'b00 && done != grant) done_bad++;
      if (prev_g == 2'b00 && grant != 2'b00) begin
        if (ngr < 4) order[ngr] = grant;
        ngr++;
      end
      prev_g = grant;
      done_prev = |done;
    end
    req_valid = 2'b00;
    n_tests++;
    if (ngr != 4) begin n_fail++; $display("FAIL rr_count got %0d grants want 4", ngr); end
    for (int k = 0; k < 4 && k < ngr; k++) begin
      n_tests++;
      if (order[k] !== ((k % 2 == 0) ? 2'b01 : 2'b10))
        begin n_fail++; $display("FAIL rr_order k=%0d got %b want %b", k, order[k], (k % 2 == 0) ? 2'b01 : 2'b10); end
    end
    n_tests++;
    if (overlaps != 0 || gap_bad != 0 || done_bad != 0)
      begin n_fail++; $display("FAIL rr_gaps overlaps=%0d gap_bad=%0d done_bad=%0d want 0", overlaps, gap_bad, done_bad); end
    n_tests++;
    if (miss_cnt0 !== 4'd2 || miss_cnt1 !== 4'd2)
      begin n_fail++; $display("FAIL rr_cnt c0=%0d c1=%0d want 2 2", miss_cnt0, miss_cnt1); end
    @(negedge clk);
  endtask

  task automatic test_slow_ack();
    int   nack = 0, slot = 0;
    logic prev_ack = 1'b0, got_done = 1'b0;
    req_addr0 = 32'h0000_2000; req_wb = 2'b00; mem_ack = 1'b0; req_valid = 2'b01;
    for (int c = 0; c < 80 && !got_done; c++) begin
      @(negedge clk);
      n_tests++;
      if (rvalid !== (prev_ack ? 2'b01 : 2'b00))
        begin n_fail++; $display("FAIL slow_rvalid c=%0d got %b want %b", c, rvalid, prev_ack ? 2'b01 : 2'b00); end
      if (prev_ack) begin
        n_tests++;
        if (word_idx !== 3'(nack - 1) || rdata !== ((32'h2000 + 32'(4 * (nack - 1))) ^ KEY))
          begin n_fail++; $display("FAIL slow_data c=%0d idx=%0d rdata=%h want idx=%0d", c, word_idx, rdata, nack - 1); end
      end
      if (done != 2'b00) begin
        got_done = 1'b1;
        req_valid = 2'b00;
        n_tests++;
        if (done !== 2'b01 || nack != 8)
          begin n_fail++; $display("FAIL slow_done done=%b acks=%0d want 01 8", done, nack); end
      end
      prev_ack = 1'b0;
      mem_ack  = 1'b0;
      if (mem_req) begin
        slot++;
        if (slot % 3 == 0) begin
          n_tests++;
          if (mem_addr !== 32'h2000 + 32'(4 * nack))
            begin n_fail++; $display("FAIL slow_addr got %h want %h", mem_addr, 32'h2000 + 32'(4 * nack)); end
          mem_ack = 1'b1; prev_ack = 1'b1; nack++;
        end
      end
    end
    n_tests++;
    if (!got_done) begin n_fail++; $display("FAIL slow_timeout done=0 want done within 80 cycles"); end
    req_valid = 2'b00; mem_ack = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic found = 1'b0, got_done = 1'b0;
    req_addr0 = 32'h0000_3000; req_wb = 2'b00; mem_ack = 1'b1; req_valid = 2'b01;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (mem_req && mem_addr == 32'h3010) found = 1'b1;
    end
    n_tests++;
    if (!found) begin n_fail++; $display("FAIL rmid_reach addr=%h want 00003010", mem_addr); end
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if (grant !== 2'b00 || mem_req !== 1'b0 || mem_addr !== 32'h0 || rvalid !== 2'b00 || done !== 2'b00)
      begin n_fail++; $display("FAIL rmid_async grant=%b req=%b addr=%h rvalid=%b done=%b want 0", grant, mem_req, mem_addr, rvalid, done); end
    n_tests++;
    if (word_idx !== 3'd0 || rdata !== 32'h0 || miss_cnt0 !== 4'd0 || miss_cnt1 !== 4'd0)
      begin n_fail++; $display("FAIL rmid_clear idx=%0d rdata=%h c0=%0d c1=%0d want 0", word_idx, rdata, miss_cnt0, miss_cnt1); end
    @(negedge clk);
    n_tests++;
    if (done !== 2'b00 || grant !== 2'b00)
      begin n_fail++; $display("FAIL rmid_hold done=%b grant=%b want 0", done, grant); end
    reset = 1'b1;
    @(negedge clk);
    n_tests++;
    if (grant !== 2'b01) begin n_fail++; $display("FAIL rmid_regrant got %b want 01", grant); end
    @(negedge clk);
    n_tests++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h3000)
      begin n_fail++; $display("FAIL rmid_restart req=%b addr=%h want 1 00003000", mem_req, mem_addr); end
    @(negedge clk);
    n_tests++;
    if (rvalid !== 2'b01 || word_idx !== 3'd0 || rdata !== (32'h3000 ^ KEY))
      begin n_fail++; $display("FAIL rmid_word0 rvalid=%b idx=%0d rdata=%h want 01 0 %h", rvalid, word_idx, rdata, 32'h3000 ^ KEY); end
    for (int c = 0; c < 20 && !got_done; c++) begin
      @(negedge clk);
      if (done != 2'b00) begin got_done = 1'b1; req_valid = 2'b00; end
    end
    @(negedge clk);
    n_tests++;
    if (!got_done || miss_cnt0 !== 4'd1)
      begin n_fail++; $display("FAIL rmid_finish done_seen=%b c0=%0d want 1 1", got_done, miss_cnt0); end
  endtask

  task automatic test_saturation();
    logic got_done;
    req_addr0 = 32'h0000_5000; req_wb = 2'b00; mem_ack = 1'b1; req_valid = 2'b00;
    pulse_reset();
    for (int i = 1; i <= 19; i++) begin
      req_valid = 2'b01;
      got_done  = 1'b0;
      for (int c = 0; c < 20 && !got_done; c++) begin
        @(negedge clk);
        if (done != 2'b00) begin got_done = 1'b1; req_valid = 2'b00; end
      end
      req_valid = 2'b00;
      @(negedge clk);
      n_tests++;
      if (!got_done || miss_cnt0 !== ((i > 15) ? 4'hF : 4'(i)))
        begin n_fail++; $display("FAIL sat i=%0d done_seen=%b cnt=%0d want %0d", i, got_done, miss_cnt0, (i > 15) ? 15 : i); end
    end
  endtask

  initial begin
    test_reset();
    test_port0_clean();
    test_port1_dirty();
    test_round_robin();
    test_slow_ack();
    test_reset_mid();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

endmodule
